// File: rtl/remap_table_ctrl.sv
// remap_table_ctrl
//   Sequencer and write-port arbiter for the remap register file.
//   Owns the file's write port and debug read address. Runs three bulk
//   operations (CLEAR, LOAD from pipe-in, DUMP to pipe-out). When idle, it
//   forwards single host writes and the host read address to the file.
//
// Ports
//   okClk, reset           clock, synchronous active-high reset
//   start, op              command pulse and opcode (0 CLEAR, 1 LOAD, 2 DUMP)
//   pi_write/pi_data       pipe-in word strobe/data, pi_ready while in LOAD
//   po_read/po_data        pipe-out pop strobe/data, po_ready while word held
//   host_we/waddr/wdata    direct host write request (honoured only when idle)
//   host_raddr             direct host read address (honoured only when idle)
//   rf_we/waddr/wdata      registered register-file write port
//   rf_raddr, rf_rdata     registered read address, combinational read data
//   busy, done, err        status: running, sticky completion, sticky error
//   count                  saturating progress counter
module remap_table_ctrl #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned AW    = 7,
   parameter int unsigned DW    = 7
) (
   input  logic          okClk,
   input  logic          reset,
   input  logic          start,
   input  logic [1:0]    op,
   input  logic          pi_write,
   input  logic [31:0]   pi_data,
   output logic          pi_ready,
   input  logic          po_read,
   output logic [31:0]   po_data,
   output logic          po_ready,
   input  logic          host_we,
   input  logic [AW-1:0] host_waddr,
   input  logic [DW-1:0] host_wdata,
   input  logic [AW-1:0] host_raddr,
   output logic          rf_we,
   output logic [AW-1:0] rf_waddr,
   output logic [DW-1:0] rf_wdata,
   output logic [AW-1:0] rf_raddr,
   input  logic [DW-1:0] rf_rdata,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [7:0]    count
);

   localparam int unsigned NWORDS = DEPTH / 4;
   localparam int unsigned WW     = AW - 2;

   // Bits a pipe-in word may legally carry: data, address and last flag.
   localparam logic [31:0] PI_LEGAL = 32'h8000_0000
                                    | ((32'd1 << DW) - 32'd1)
                                    | (((32'd1 << AW) - 32'd1) << 8);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_LOAD,
      S_DUMP_GATHER,
      S_DUMP_OUT
   } state_t;

   state_t               state_q, state_d;
   logic                 rf_we_q, rf_we_d;
   logic [AW-1:0]        rf_waddr_q, rf_waddr_d;
   logic [DW-1:0]        rf_wdata_q, rf_wdata_d;
   logic [AW-1:0]        rf_raddr_q, rf_raddr_d;
   logic [31:0]          po_data_q, po_data_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [7:0]           count_q, count_d;
   logic [AW:0]          clr_q, clr_d;
   logic [WW-1:0]        word_q, word_d;
   logic [2:0]           phase_q, phase_d;
   logic [3:0][DW-1:0]   gbuf_q, gbuf_d;
   logic                 err_set;
   logic [31:0]          packed_word;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge okClk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
         rf_raddr_q <= '0;
         po_data_q  <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         count_q    <= '0;
         clr_q      <= '0;
         word_q     <= '0;
         phase_q    <= '0;
         gbuf_q     <= '0;
      end else begin
         state_q    <= state_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
         rf_raddr_q <= rf_raddr_d;
         po_data_q  <= po_data_d;
         done_q     <= done_d;
         err_q      <= err_d;
         count_q    <= count_d;
         clr_q      <= clr_d;
         word_q     <= word_d;
         phase_q    <= phase_d;
         gbuf_q     <= gbuf_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      rf_we_d     = 1'b0;
      rf_waddr_d  = rf_waddr_q;
      rf_wdata_d  = rf_wdata_q;
      rf_raddr_d  = rf_raddr_q;
      po_data_d   = po_data_q;
      done_d      = done_q;
      err_d       = err_q;
      count_d     = count_q;
      clr_d       = clr_q;
      word_d      = word_q;
      phase_d     = phase_q;
      gbuf_d      = gbuf_q;
      err_set     = 1'b0;
      packed_word = '0;

      // Each gathered entry sits in its own zero-padded byte lane.
      for (int unsigned j = 0; j < 4; j++) begin
         packed_word[8*j +: 8] = {{(8-DW){1'b0}}, gbuf_q[j]};
      end

      if (pi_write && state_q != S_LOAD)    err_set = 1'b1;
      if (po_read  && state_q != S_DUMP_OUT) err_set = 1'b1;
      if (host_we  && state_q != S_IDLE)    err_set = 1'b1;
      if (start    && state_q != S_IDLE)    err_set = 1'b1;

      case (state_q)
         S_IDLE: begin
            rf_raddr_d = host_raddr;
            if (host_we) begin
               rf_we_d    = 1'b1;
               rf_waddr_d = host_waddr;
               rf_wdata_d = host_wdata;
            end
            if (start) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               count_d = '0;
               case (op)
                  2'd0: begin
                     // Address 0 is issued from the accepting cycle so the
                     // write burst starts on the first busy cycle; a host
                     // write in the same cycle loses the port.
                     state_d    = S_CLEAR;
                     rf_we_d    = 1'b1;
                     rf_waddr_d = '0;
                     rf_wdata_d = '0;
                     clr_d      = (AW+1)'(1);
                     count_d    = 8'd1;
                     if (host_we) err_set = 1'b1;
                  end
                  2'd1: state_d = S_LOAD;
                  2'd2: begin
                     state_d    = S_DUMP_GATHER;
                     word_d     = '0;
                     phase_d    = '0;
                     rf_raddr_d = '0;
                  end
                  default: begin
                     done_d  = 1'b1;
                     err_set = 1'b1;
                  end
               endcase
            end
         end

         S_CLEAR: begin
            if (clr_q == (AW+1)'(DEPTH)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               rf_we_d    = 1'b1;
               rf_waddr_d = clr_q[AW-1:0];
               rf_wdata_d = '0;
               clr_d      = clr_q + (AW+1)'(1);
               count_d    = sat_inc(count_q);
            end
         end

         S_LOAD: begin
            if (pi_write) begin
               if (|(pi_data & ~PI_LEGAL)) begin
                  err_set = 1'b1;
               end else begin
                  rf_we_d    = 1'b1;
                  rf_waddr_d = pi_data[8 +: AW];
                  rf_wdata_d = pi_data[DW-1:0];
                  count_d    = sat_inc(count_q);
               end
               if (pi_data[31]) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         S_DUMP_GATHER: begin
            // Phases 0..3 capture entries 4k..4k+3; phase 4 packs the word.
            if (phase_q < 3'd4) begin
               gbuf_d[phase_q[1:0]] = rf_rdata;
               if (phase_q < 3'd3) rf_raddr_d = rf_raddr_q + AW'(1);
               phase_d = phase_q + 3'd1;
            end else begin
               po_data_d = packed_word;
               state_d   = S_DUMP_OUT;
            end
         end

         S_DUMP_OUT: begin
            if (po_read) begin
               count_d = sat_inc(count_q);
               if (word_q == WW'(NWORDS - 1)) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  word_d     = word_q + WW'(1);
                  phase_d    = '0;
                  rf_raddr_d = {word_q + WW'(1), 2'b00};
                  state_d    = S_DUMP_GATHER;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      err_d = err_d | err_set;
   end

   assign pi_ready = (state_q == S_LOAD);
   assign po_ready = (state_q == S_DUMP_OUT);
   assign po_data  = po_data_q;
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign count    = count_q;
   assign rf_we    = rf_we_q;
   assign rf_waddr = rf_waddr_q;
   assign rf_wdata = rf_wdata_q;
   assign rf_raddr = rf_raddr_q;

endmodule

// File: doc/remap_table_ctrl.md
# remap_table_ctrl

Sequencer and write-port arbiter for the 128-entry x 7-bit remap register file. Owns the file's write port (`rf_we`/`rf_waddr`/`rf_wdata`) and its debug read address. Runs three host-triggered bulk operations: CLEAR, LOAD from a pipe-in word stream, and DUMP to a pipe-out word stream. When idle, it forwards single host wire writes and reads to the file.

## Interface
Parameters:
- `DEPTH`, 128, number of map entries (power of two).
- `AW`, 7, address width (log2 `DEPTH`).
- `DW`, 7, entry width.

Ports:
- `okClk`: in, 1, clock.
- `reset`: in, 1, synchronous, active-high.
- `start`: in, 1, one-cycle command pulse (trigger-in bit).
- `op`: in, 2, command sampled with `start`: 0 = CLEAR, 1 = LOAD, 2 = DUMP, 3 = reserved.
- `pi_write`: in, 1, pipe-in word strobe.
- `pi_data`: in, 32, pipe-in word.
- `pi_ready`: out, 1, controller accepts pipe-in words.
- `po_read`: in, 1, pipe-out pop strobe.
- `po_data`: out, 32, pipe-out word.
- `po_ready`: out, 1, `po_data` is valid.
- `host_we`: in, 1, direct host write request.
- `host_waddr`: in, AW, direct host write address.
- `host_wdata`: in, DW, direct host write data.
- `host_raddr`: in, AW, direct host read address.
- `rf_we`: out, 1, register-file write enable.
- `rf_waddr`: out, AW, register-file write address.
- `rf_wdata`: out, DW, register-file write data.
- `rf_raddr`: out, AW, register-file read address.
- `rf_rdata`: in, DW, register-file read data (combinational, same cycle as `rf_raddr`).
- `busy`: out, 1, an operation is in progress.
- `done`: out, 1, sticky; set when an operation completes, cleared by the next accepted `start`.
- `err`: out, 1, sticky; cleared by the next accepted `start`.
- `count`: out, 8, saturating progress counter, cleared by an accepted `start`.

## Operation
- States are IDLE, CLEAR, LOAD, DUMP_GATHER and DUMP_OUT.
- **Reset**: state IDLE. All outputs are 0, including `rf_raddr`, `po_data`, `count`, `done` and `err`. The controller never clears the file itself; the file has its own reset.
- **IDLE**:
  - `host_we` is forwarded as a write.
  - `rf_raddr` follows `host_raddr`, registered.
  - `start` with `op` 0, 1 or 2 moves to CLEAR, LOAD or DUMP_GATHER respectively.
  - `op` = 3 stays in IDLE and sets `done` and `err`.
- **CLEAR**:
  - Writes 0 to addresses 0 through `DEPTH`-1, one per cycle, in ascending order.
  - `count` increments per write.
  - After address `DEPTH`-1 the state returns to IDLE and `done` is set.
- **LOAD**:
  - `pi_ready` = 1.
  - Word format: [6:0] data, [14:8] address, [31] last; every other bit must be 0.
  - A well-formed word is written and `count` increments.
  - A malformed word sets `err` and is not written. Its last bit is still honoured.
  - A word with last = 1 ends LOAD: the state returns to IDLE and `done` is set.
- **DUMP_GATHER**:
  - Reads 4 consecutive entries, one per cycle, from `rf_raddr` = 4k .. 4k+3.
  - Packs them into `po_data` = {1'b0, e[4k+3], 1'b0, e[4k+2], 1'b0, e[4k+1], 1'b0, e[4k]}, then moves to DUMP_OUT.
- **DUMP_OUT**:
  - `po_ready` = 1 and `po_data` is held.
  - `po_read` consumes the word and increments `count`.
  - The next state is DUMP_GATHER for k+1, or IDLE with `done` set after word `DEPTH`/4-1 (32 words).
- **Arbitration**: while `busy` = 1, the controller owns the write port. `host_we` is dropped and sets `err`. `host_raddr` is ignored.
- **Protocol errors**: each of the following is ignored and sets `err`:
  - `pi_write` outside LOAD.
  - `po_read` while `po_ready` = 0.
  - `start` while `busy` = 1. This does not disturb the running operation and does not clear `done` or `err`.
- **Reset mid-operation**: reset aborts at the next edge. No further `rf_we` is issued, and pending pipe words are discarded.
- **`count`** saturates at 255.

## Timing
- `busy` rises on the cycle after `start` and falls in the same cycle that `done` rises.
- All `rf_*` outputs are registered. A write request in cycle t (from `host_we`, an accepted `pi_write`, or a CLEAR step) produces `rf_we` = 1 in cycle t+1 with matching address and data.
- **CLEAR**: with `start` at t, `rf_we` is 1 in cycles t+1 .. t+128 with `rf_waddr` 0..127. `done` = 1 and `busy` = 0 from t+129.
- **LOAD**:
  - Back-to-back `pi_write` at one word per cycle is supported with no stall.
  - For a last word at t, `rf_we` is at t+1 and `done` rises at t+1.
- **DUMP**:
  - Gather takes 4 cycles per word.
  - `po_ready` rises 5 cycles after entering DUMP_GATHER (4 reads plus 1 register stage).
  - `po_ready` drops on the cycle after `po_read`.
  - With zero host stall, the whole 32-word dump completes in 32 × 6 cycles.
- `po_data` changes only while `po_ready` = 0.

## Test plan
- **Reset then CLEAR**: preload entries 5 = 0x2A and 127 = 0x7F via host writes, then `start` with `op` = 0. Required:
  - 128 consecutive `rf_we` pulses with addresses 0..127 and data 0.
  - `done` at t+129 and `count` = 128.
  - A subsequent DUMP returns 32 zero words.
- **LOAD 3 words**: words 0x0000_0305, 0x0000_7F11, 0x8000_4001. Required:
  - Writes map[3] = 5, map[127] = 0x11, map[64] = 1.
  - `count` = 3, `done` = 1, `err` = 0.
- **Malformed LOAD word**: send 0x0001_0203, then 0x8000_0000. Required:
  - The first word is not written.
  - map[0] = 0 is written.
  - `err` = 1 and `done` = 1.
- **DUMP after map[0..3] = 1,2,3,4**: hold `po_read` low for 10 cycles, then pop. Required:
  - The first word is 0x0403_0201, held stable while stalled.
  - 32 words in total, then `done` = 1 and `count` = 32.
- **Arbitration and collisions**:
  - `host_we` during CLEAR: no write to the host address, `err` = 1, and CLEAR still ends with 128 writes.
  - `start` during LOAD: ignored.
  - `po_read` in IDLE: sets `err`.
- **Reset mid-DUMP**: assert reset in DUMP_OUT with `po_ready` = 1. Required:
  - Next cycle `po_ready` = 0, `busy` = 0 and `count` = 0.
  - No `rf_we` is issued.
  - The file contents are unchanged.
